// File: rtl/alu_ctrl_decode_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and the
// register-read/ALU stage. The decode stage uses the slave view.
interface alu_ctrl_decode_if #(
  parameter int unsigned XLEN = 32
);
  // Upstream side (fetch -> decode)
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;

  // Downstream side (decode -> register read / ALU)
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_op;
  logic [1:0]      a_sel;
  logic            b_sel;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            reg_we;
  logic            mem_rd;
  logic            mem_wr;
  logic            branch;
  logic            jump;
  logic [XLEN-1:0] pc_out;
  logic            illegal;

  modport master (
    output flush, in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, alu_op, a_sel, b_sel, imm, rs1, rs2, rd,
           reg_we, mem_rd, mem_wr, branch, jump, pc_out, illegal
  );

  modport slave (
    input  flush, in_valid, instr, pc, out_ready,
    output in_ready, out_valid, alu_op, a_sel, b_sel, imm, rs1, rs2, rd,
           reg_we, mem_rd, mem_wr, branch, jump, pc_out, illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Registered RV32I decode stage feeding the ALU. Decodes the instruction word
// combinationally and captures the result in a one-entry output register with
// valid/ready handshaking on both sides.
module alu_ctrl_decode #(
  parameter int unsigned XLEN        = 32,
  parameter bit          ILLEGAL_NOP = 1'b1
) (
  input logic              clk,
  input logic              rst,
  alu_ctrl_decode_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Shared funct3 map of OP and OP-IMM; alt selects SUB/SRA.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  opcode_e         opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_f;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = opcode_e'(bus.instr[6:0]);
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  assign rd_f   = bus.instr[11:7];

  assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b  = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                   bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign imm_u  = {bus.instr[31:12], 12'b0};
  assign imm_j  = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                   bus.instr[20], bus.instr[30:21], 1'b0};
  assign imm_sh = {27'b0, bus.instr[24:20]};

  alu_op_e         d_alu;
  logic [1:0]      d_a_sel;
  logic            d_b_sel;
  logic [XLEN-1:0] d_imm;
  logic            d_wr_rd;
  logic            d_mem_rd;
  logic            d_mem_wr;
  logic            d_branch;
  logic            d_jump;
  logic            d_illegal;

  // Raw per-opcode decode; R-type carries no immediate so imm stays 0 there.
  always_comb begin
    d_alu     = ALU_ADD;
    d_a_sel   = 2'd0;
    d_b_sel   = 1'b0;
    d_imm     = '0;
    d_wr_rd   = 1'b0;
    d_mem_rd  = 1'b0;
    d_mem_wr  = 1'b0;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_alu     = arith_op(f3, f7[5]);
        d_wr_rd   = 1'b1;
        d_illegal = !((f7 == 7'h00) ||
                      ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        d_alu   = arith_op(f3, (f3 == 3'b101) && f7[5]);
        d_b_sel = 1'b1;
        d_wr_rd = 1'b1;
        d_imm   = ((f3 == 3'b001) || (f3 == 3'b101)) ? imm_sh : imm_i;
        if (f3 == 3'b001)
          d_illegal = (f7 != 7'h00);
        else if (f3 == 3'b101)
          d_illegal = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OPC_LUI: begin
        d_a_sel = 2'd2;
        d_b_sel = 1'b1;
        d_imm   = imm_u;
        d_wr_rd = 1'b1;
      end
      OPC_AUIPC: begin
        d_a_sel = 2'd1;
        d_b_sel = 1'b1;
        d_imm   = imm_u;
        d_wr_rd = 1'b1;
      end
      OPC_LOAD: begin
        d_b_sel   = 1'b1;
        d_imm     = imm_i;
        d_wr_rd   = 1'b1;
        d_mem_rd  = 1'b1;
        d_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        d_b_sel   = 1'b1;
        d_imm     = imm_s;
        d_mem_wr  = 1'b1;
        d_illegal = f3[2] || (f3 == 3'b011);
      end
      OPC_BRANCH: begin
        d_imm     = imm_b;
        d_branch  = 1'b1;
        d_illegal = (f3[2:1] == 2'b01);
        case (f3[2:1])
          2'b00:   d_alu = ALU_SUB;
          2'b10:   d_alu = ALU_SLT;
          default: d_alu = ALU_SLTU;
        endcase
      end
      OPC_JAL: begin
        d_a_sel = 2'd1;
        d_b_sel = 1'b1;
        d_imm   = imm_j;
        d_wr_rd = 1'b1;
        d_jump  = 1'b1;
      end
      OPC_JALR: begin
        d_b_sel   = 1'b1;
        d_imm     = imm_i;
        d_wr_rd   = 1'b1;
        d_jump    = 1'b1;
        d_illegal = (f3 != 3'b000);
      end
      default: d_illegal = 1'b1;
    endcase
  end

  logic    nop;
  alu_op_e n_alu;
  logic    n_reg_we;

  // Illegal instructions optionally collapse to a side-effect-free NOP.
  assign nop      = d_illegal && ILLEGAL_NOP;
  assign n_alu    = nop ? ALU_ADD : d_alu;
  assign n_reg_we = d_wr_rd && !d_illegal && (rd_f != 5'd0);

  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  // Output register: reset beats flush, flush beats a new load.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.alu_op    <= '0;
      bus.a_sel     <= '0;
      bus.b_sel     <= 1'b0;
      bus.imm       <= '0;
      bus.rs1       <= '0;
      bus.rs2       <= '0;
      bus.rd        <= '0;
      bus.reg_we    <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.branch    <= 1'b0;
      bus.jump      <= 1'b0;
      bus.pc_out    <= '0;
      bus.illegal   <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid && bus.in_ready) begin
      bus.out_valid <= 1'b1;
      bus.alu_op    <= n_alu;
      bus.a_sel     <= d_a_sel;
      bus.b_sel     <= d_b_sel;
      bus.imm       <= d_imm;
      bus.rs1       <= bus.instr[19:15];
      bus.rs2       <= bus.instr[24:20];
      bus.rd        <= rd_f;
      bus.reg_we    <= n_reg_we;
      bus.mem_rd    <= d_mem_rd && !nop;
      bus.mem_wr    <= d_mem_wr && !nop;
      bus.branch    <= d_branch && !nop;
      bus.jump      <= d_jump && !nop;
      bus.pc_out    <= bus.pc;
      bus.illegal   <= d_illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: directed cases followed by random traffic, all
// checked against an instruction-level reference decoder and a one-entry
// handshake model.
module tb_alu_ctrl_decode;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
    logic        illegal;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic        m_valid;
  exp_t        m_ent;
  logic [31:0] m_pc;

  alu_ctrl_decode_if #(.XLEN(32)) bus ();

  alu_ctrl_decode #(.XLEN(32), .ILLEGAL_NOP(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder written from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   op, f3, f7, alu, ival, sval, bval, jval;
    int   tab[8];
    bit   legal, writes;
    tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    op  = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    ival = int'(w) >>> 20;
    sval = (int'(w) >>> 25) * 32 + int'(w[11:7]);
    bval = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    jval = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    e = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    legal = 1; writes = 0; alu = 0;
    if (op == 'h33) begin
      legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      alu = tab[f3] + ((f7 == 32) ? 1 : 0);
      writes = 1;
    end else if (op == 'h13) begin
      e.b_sel = 1; writes = 1;
      if (f3 == 1) begin
        legal = (f7 == 0); alu = 2; e.imm = 32'(w[24:20]);
      end else if (f3 == 5) begin
        legal = (f7 == 0 || f7 == 32); alu = 6 + ((f7 == 32) ? 1 : 0); e.imm = 32'(w[24:20]);
      end else begin
        alu = tab[f3]; e.imm = ival;
      end
    end else if (op == 'h37 || op == 'h17) begin
      e.a_sel = (op == 'h37) ? 2'd2 : 2'd1;
      e.b_sel = 1; e.imm = w & 32'hFFFFF000; writes = 1;
    end else if (op == 'h03) begin
      e.b_sel = 1; e.imm = ival; e.mem_rd = 1; writes = 1;
      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    end else if (op == 'h23) begin
      e.b_sel = 1; e.imm = sval; e.mem_wr = 1; legal = (f3 <= 2);
    end else if (op == 'h63) begin
      e.imm = bval; e.branch = 1; legal = (f3 != 2 && f3 != 3);
      alu = (f3 < 2) ? 1 : ((f3 < 6) ? 3 : 4);
    end else if (op == 'h6F) begin
      e.a_sel = 1; e.b_sel = 1; e.imm = jval; e.jump = 1; writes = 1;
    end else if (op == 'h67) begin
      e.b_sel = 1; e.imm = ival; e.jump = 1; writes = 1; legal = (f3 == 0);
    end else begin
      legal = 0;
    end
    e.alu_op  = legal ? 4'(alu) : 4'd0;
    e.illegal = !legal;
    e.reg_we  = writes && legal && (e.rd != 0);
    if (!legal) begin
      e.mem_rd = 0; e.mem_wr = 0; e.branch = 0; e.jump = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opc[9];
    int          k;
    opc = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = opc[k];
    if ((k < 2) && ($urandom_range(0, 1) == 1)) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("pc_out", bus.pc_out, m_pc);
    check("alu_op", 32'(bus.alu_op), 32'(m_ent.alu_op));
    check("rs1", 32'(bus.rs1), 32'(m_ent.rs1));
    check("rs2", 32'(bus.rs2), 32'(m_ent.rs2));
    check("rd", 32'(bus.rd), 32'(m_ent.rd));
    check("reg_we", 32'(bus.reg_we), 32'(m_ent.reg_we));
    check("mem_rd", 32'(bus.mem_rd), 32'(m_ent.mem_rd));
    check("mem_wr", 32'(bus.mem_wr), 32'(m_ent.mem_wr));
    check("branch", 32'(bus.branch), 32'(m_ent.branch));
    check("jump", 32'(bus.jump), 32'(m_ent.jump));
    check("illegal", 32'(bus.illegal), 32'(m_ent.illegal));
    if (!m_ent.illegal) begin
      check("a_sel", 32'(bus.a_sel), 32'(m_ent.a_sel));
      check("b_sel", 32'(bus.b_sel), 32'(m_ent.b_sel));
      check("imm", bus.imm, m_ent.imm);
    end
  endtask

  // One clock of traffic: drive, check in_ready, advance the model, compare.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p,
                      input bit ordy, input bit fl, input bit r);
    bit accept;
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc        = p;
    bus.out_ready = ordy;
    bus.flush     = fl;
    rst           = r;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
    accept = v && (!m_valid || ordy);
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_ent = '0; m_pc = '0;
    end else if (fl) begin
      m_valid = 0;
    end else if (accept) begin
      m_valid = 1; m_ent = ref_decode(ins); m_pc = p;
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    compare_all();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 0; m_ent = '0; m_pc = '0;

    // Reset state
    step(0, 32'h0, 32'h0, 0, 0, 1);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_imm", bus.imm, 32'h0);

    // add x3,x1,x2 visible one cycle after acceptance
    step(1, 32'h002081B3, 32'h1000, 1, 0, 0);
    check("add_valid", 32'(bus.out_valid), 32'h1);
    check("add_alu", 32'(bus.alu_op), 32'd0);
    check("add_asel", 32'(bus.a_sel), 32'd0);
    check("add_bsel", 32'(bus.b_sel), 32'd0);
    check("add_rd", 32'(bus.rd), 32'd3);
    check("add_rs1", 32'(bus.rs1), 32'd1);
    check("add_rs2", 32'(bus.rs2), 32'd2);
    check("add_we", 32'(bus.reg_we), 32'd1);

    // srai x5,x6,3 and the malformed variant
    step(1, 32'h40335293, 32'h1004, 1, 0, 0);
    check("srai_alu", 32'(bus.alu_op), 32'd7);
    check("srai_bsel", 32'(bus.b_sel), 32'd1);
    check("srai_imm", bus.imm, 32'd3);
    check("srai_rd", 32'(bus.rd), 32'd5);
    step(1, 32'h42335293, 32'h1008, 1, 0, 0);
    check("badsrai_ill", 32'(bus.illegal), 32'd1);
    check("badsrai_we", 32'(bus.reg_we), 32'd0);

    // lui with and without a destination
    step(1, 32'h123450B7, 32'h100C, 1, 0, 0);
    check("lui_alu", 32'(bus.alu_op), 32'd0);
    check("lui_asel", 32'(bus.a_sel), 32'd2);
    check("lui_imm", bus.imm, 32'h12345000);
    check("lui_we", 32'(bus.reg_we), 32'd1);
    step(1, 32'h12345037, 32'h1010, 1, 0, 0);
    check("lui0_we", 32'(bus.reg_we), 32'd0);

    // blt x1,x2,-4
    step(1, 32'hFE20CEE3, 32'h1014, 1, 0, 0);
    check("blt_alu", 32'(bus.alu_op), 32'd3);
    check("blt_br", 32'(bus.branch), 32'd1);
    check("blt_we", 32'(bus.reg_we), 32'd0);
    check("blt_imm", bus.imm, 32'hFFFFFFFC);

    // Back-pressure: sub held for 3 cycles while the next instr waits
    step(1, 32'h402081B3, 32'h2000, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00C5F533, 32'h2004, 0, 0, 0);
      check("hold_inrdy", 32'(bus.in_ready), 32'd0);
      check("hold_alu", 32'(bus.alu_op), 32'd1);
      check("hold_pc", bus.pc_out, 32'h2000);
    end
    step(1, 32'h00C5F533, 32'h2004, 1, 0, 0);
    check("release_alu", 32'(bus.alu_op), 32'd9);
    check("release_pc", bus.pc_out, 32'h2004);

    // Flush while an input would be accepted, and while held
    step(1, 32'h002081B3, 32'h3000, 1, 1, 0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    step(1, 32'h002081B3, 32'h3004, 1, 0, 0);
    step(1, 32'h40335293, 32'h3008, 0, 1, 0);
    check("flush_hold_valid", 32'(bus.out_valid), 32'd0);

    // Reset while holding a non-zero op drops the entry; reset beats flush
    step(1, 32'h402081B3, 32'h4000, 1, 0, 0);
    step(1, 32'h002081B3, 32'h4004, 0, 0, 0);
    step(1, 32'h002081B3, 32'h4008, 0, 1, 1);
    check("rsthold_valid", 32'(bus.out_valid), 32'd0);
    check("rsthold_alu", 32'(bus.alu_op), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
